// File: rtl/sb_param_pkg.sv
// Shared sizing helpers and track index maps for the parametrised corner switch block.
package sb_param_pkg;

    localparam int SEL_OFS = 0;
    localparam int EN_OFS  = 1;

    // Two muxes (bottom + left) per muxed track, each needing a sel and an en bit.
    function automatic int cfg_bits(input int m);
        return 4 * m;
    endfunction

    function automatic int cnt_w(input int bits);
        return $clog2(bits + 1);
    endfunction

    function automatic int bot_in1_idx(input int i, input int w);
        return (i + 1) % w;
    endfunction

    function automatic int left_in0_idx(input int i, input int w);
        return (i + w - 1) % w;
    endfunction

    function automatic int pass_src_idx(input int k, input int m, input int w);
        return (m + 1 + k) % w;
    endfunction

endpackage

// File: rtl/sb_cfg_dbuf_chain.sv
// Double-buffered configuration chain: serial shift stage, committed active shadow,
// bit counter and status flags.
module sb_cfg_dbuf_chain
    import sb_param_pkg::*;
#(
    parameter int  CFG_BITS = 24,
    localparam int CNT_W    = cnt_w(CFG_BITS)
)(
    input  logic                prog_clk,
    input  logic                prog_reset,
    input  logic                ccff_head,
    input  logic                ccff_shift_en,
    input  logic                cfg_commit,
    output logic [CFG_BITS-1:0] active,
    output logic                ccff_tail,
    output logic [CNT_W-1:0]    cfg_bit_cnt,
    output logic                cfg_full,
    output logic                cfg_active,
    output logic                cfg_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_BITS);

    logic [CFG_BITS-1:0] shift_q, shift_d;
    logic [CFG_BITS-1:0] active_q, active_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                act_q, act_d;
    logic                err_q, err_d;
    logic                full;
    logic                commit_ok;

    assign full      = (cnt_q == CNT_MAX);
    assign commit_ok = cfg_commit && full;

    always_comb begin
        shift_d  = shift_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        act_d    = act_q;
        err_d    = err_q;

        if (ccff_shift_en)
            shift_d = {shift_q[CFG_BITS-2:0], ccff_head};

        // Commit captures the pre-edge shift stage; a simultaneous shift starts the next count at 1.
        if (commit_ok) begin
            active_d = shift_q;
            act_d    = 1'b1;
            cnt_d    = {{(CNT_W-1){1'b0}}, ccff_shift_en};
        end else begin
            if (cfg_commit)
                err_d = 1'b1;
            if (ccff_shift_en && !full)
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            shift_q  <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            act_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            act_q    <= act_d;
            err_q    <= err_d;
        end
    end

    assign active      = active_q;
    assign ccff_tail   = shift_q[CFG_BITS-1];
    assign cfg_bit_cnt = cnt_q;
    assign cfg_full    = full;
    assign cfg_active  = act_q;
    assign cfg_err     = err_q;

endmodule

// File: rtl/sb_param_dbuf.sv
// Parametrised bottom/left corner switch block: 2:1 muxed tracks driven from the
// committed configuration, plus always-live pass-through tracks.
module sb_param_dbuf
    import sb_param_pkg::*;
#(
    parameter int  CHAN_W   = 9,
    parameter int  N_PASS   = 3,
    localparam int M        = CHAN_W - N_PASS,
    localparam int CFG_BITS = cfg_bits(M),
    localparam int CNT_W    = cnt_w(CFG_BITS)
)(
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              ccff_head,
    input  logic              ccff_shift_en,
    input  logic              cfg_commit,
    input  logic [CHAN_W-1:0] chany_bottom_in,
    input  logic [CHAN_W-1:0] chanx_left_in,
    input  logic [M-1:0]      bottom_pin_in,
    input  logic [M-1:0]      left_pin_in,
    output logic [CHAN_W-1:0] chany_bottom_out,
    output logic [CHAN_W-1:0] chanx_left_out,
    output logic              ccff_tail,
    output logic [CNT_W-1:0]  cfg_bit_cnt,
    output logic              cfg_full,
    output logic              cfg_active,
    output logic              cfg_err
);

    logic [CFG_BITS-1:0] active;

    sb_cfg_dbuf_chain #(
        .CFG_BITS (CFG_BITS)
    ) u_chain (
        .prog_clk      (prog_clk),
        .prog_reset    (prog_reset),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .cfg_commit    (cfg_commit),
        .active        (active),
        .ccff_tail     (ccff_tail),
        .cfg_bit_cnt   (cfg_bit_cnt),
        .cfg_full      (cfg_full),
        .cfg_active    (cfg_active),
        .cfg_err       (cfg_err)
    );

    // Muxes j=0..M-1 feed the bottom side, j=M..2M-1 the left side.
    for (genvar i = 0; i < M; i++) begin : g_mux
        logic b_sel, b_en, l_sel, l_en;

        assign b_sel = active[2*i + SEL_OFS];
        assign b_en  = active[2*i + EN_OFS];
        assign l_sel = active[2*(M+i) + SEL_OFS];
        assign l_en  = active[2*(M+i) + EN_OFS];

        assign chany_bottom_out[i] = (cfg_active && b_en)
            ? (b_sel ? chanx_left_in[bot_in1_idx(i, CHAN_W)] : bottom_pin_in[i])
            : 1'b0;

        assign chanx_left_out[i] = (cfg_active && l_en)
            ? (l_sel ? left_pin_in[i] : chany_bottom_in[left_in0_idx(i, CHAN_W)])
            : 1'b0;
    end

    for (genvar k = 0; k < N_PASS; k++) begin : g_pass
        assign chanx_left_out[M+k]   = chany_bottom_in[M-1+k];
        assign chany_bottom_out[M+k] = chanx_left_in[pass_src_idx(k, M, CHAN_W)];
    end

endmodule

// File: tb/tb_sb_param_dbuf.sv
// Directed bench for sb_param_dbuf with a behavioural reference model checked every cycle.
module tb_sb_param_dbuf;

    localparam int W   = 9;
    localparam int NP  = 3;
    localparam int M   = W - NP;
    localparam int CFG = 4 * M;
    localparam int CW  = $clog2(CFG + 1);

    logic          prog_clk = 1'b0;
    logic          prog_reset;
    logic          ccff_head, ccff_shift_en, cfg_commit;
    logic [W-1:0]  chany_bottom_in, chanx_left_in;
    logic [M-1:0]  bottom_pin_in, left_pin_in;
    logic [W-1:0]  chany_bottom_out, chanx_left_out;
    logic          ccff_tail;
    logic [CW-1:0] cfg_bit_cnt;
    logic          cfg_full, cfg_active, cfg_err;

    int n_chk  = 0;
    int n_fail = 0;

    sb_param_dbuf #(.CHAN_W(W), .N_PASS(NP)) dut (
        .prog_clk         (prog_clk),
        .prog_reset       (prog_reset),
        .ccff_head        (ccff_head),
        .ccff_shift_en    (ccff_shift_en),
        .cfg_commit       (cfg_commit),
        .chany_bottom_in  (chany_bottom_in),
        .chanx_left_in    (chanx_left_in),
        .bottom_pin_in    (bottom_pin_in),
        .left_pin_in      (left_pin_in),
        .chany_bottom_out (chany_bottom_out),
        .chanx_left_out   (chanx_left_out),
        .ccff_tail        (ccff_tail),
        .cfg_bit_cnt      (cfg_bit_cnt),
        .cfg_full         (cfg_full),
        .cfg_active       (cfg_active),
        .cfg_err          (cfg_err)
    );

    initial forever #5 prog_clk = ~prog_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the bitstream is an ordered list; active is a snapshot of it.
    bit m_sr  [CFG];
    bit m_act [CFG];
    int m_cnt  = 0;
    bit m_on   = 0;
    bit m_err  = 0;

    always @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            for (int i = 0; i < CFG; i++) begin
                m_sr[i]  = 0;
                m_act[i] = 0;
            end
            m_cnt = 0; m_on = 0; m_err = 0;
        end else begin
            bit ok;
            ok = cfg_commit && (m_cnt == CFG);
            if (ok) begin
                for (int i = 0; i < CFG; i++) m_act[i] = m_sr[i];
                m_on = 1;
            end else if (cfg_commit) begin
                m_err = 1;
            end
            if (ccff_shift_en) begin
                for (int i = CFG - 1; i > 0; i--) m_sr[i] = m_sr[i-1];
                m_sr[0] = ccff_head;
            end
            if (ok) m_cnt = ccff_shift_en ? 1 : 0;
            else if (ccff_shift_en && m_cnt < CFG) m_cnt = m_cnt + 1;
        end
    end

    always @(negedge prog_clk) begin : cmp
        logic [W-1:0] eb, el;
        eb = '0; el = '0;
        for (int i = 0; i < M; i++) begin
            if (m_on && m_act[2*i+1])
                eb[i] = m_act[2*i] ? chanx_left_in[(i+1)%W] : bottom_pin_in[i];
            if (m_on && m_act[2*(M+i)+1])
                el[i] = m_act[2*(M+i)] ? left_pin_in[i] : chany_bottom_in[(i+W-1)%W];
        end
        for (int k = 0; k < NP; k++) begin
            el[M+k] = chany_bottom_in[M-1+k];
            eb[M+k] = chanx_left_in[(M+1+k)%W];
        end
        chk("bottom_out", 32'(chany_bottom_out), 32'(eb));
        chk("left_out",   32'(chanx_left_out),   32'(el));
        chk("tail",       32'(ccff_tail),        32'(m_sr[CFG-1]));
        chk("bit_cnt",    32'(cfg_bit_cnt),      32'(m_cnt));
        chk("full",       32'(cfg_full),         32'(m_cnt == CFG));
        chk("active",     32'(cfg_active),       32'(m_on));
        chk("err",        32'(cfg_err),          32'(m_err));
    end

    task automatic step(input logic head, input logic sh, input logic cm);
        ccff_head = head; ccff_shift_en = sh; cfg_commit = cm;
        @(posedge prog_clk); #1;
        ccff_head = 1'b0; ccff_shift_en = 1'b0; cfg_commit = 1'b0;
    endtask

    task automatic shift_word(input logic [CFG-1:0] w);
        for (int i = CFG - 1; i >= 0; i--) step(w[i], 1'b1, 1'b0);
    endtask

    logic [29:0] rs;

    initial begin
        prog_reset = 1'b1;
        ccff_head = 1'b0; ccff_shift_en = 1'b0; cfg_commit = 1'b0;
        chany_bottom_in = 9'h1A5;
        chanx_left_in   = 9'h0F3;
        bottom_pin_in   = 6'h01;
        left_pin_in     = 6'h04;
        repeat (2) @(posedge prog_clk);
        #1 prog_reset = 1'b0;

        // Reset state: muxed tracks low, pass-throughs live.
        #1;
        chk("rst_bottom", 32'(chany_bottom_out), 32'h140);
        chk("rst_left",   32'(chanx_left_out),   32'h140);
        chk("rst_active", 32'(cfg_active), 0);
        chk("rst_cnt",    32'(cfg_bit_cnt), 0);

        // Bottom mux 0 enabled, sel=0.
        shift_word(24'h000002);
        chk("full_pre", 32'(cfg_full), 1);
        step(1'b0, 1'b0, 1'b1);
        chk("cnt_post", 32'(cfg_bit_cnt), 0);
        chk("act_post", 32'(cfg_active), 1);
        chk("mux0_pin1", 32'(chany_bottom_out), 32'h141);
        bottom_pin_in = 6'h00; #1;
        chk("mux0_pin0", 32'(chany_bottom_out), 32'h140);
        bottom_pin_in = 6'h01; #1;

        // Early commit is rejected.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("early_err", 32'(cfg_err), 1);
        chk("early_cnt", 32'(cfg_bit_cnt), 10);
        chk("early_out", 32'(chany_bottom_out), 32'h141);

        // New stream shifts in behind the active config; applies only on commit.
        shift_word(24'h032003);
        bottom_pin_in = 6'h00; #1;
        chk("pre_commit_b", 32'(chany_bottom_out), 32'h140);
        chk("pre_commit_l", 32'(chanx_left_out),   32'h140);
        step(1'b0, 1'b0, 1'b1);
        chk("new_bottom", 32'(chany_bottom_out), 32'h141);
        chk("new_left",   32'(chanx_left_out),   32'h145);

        // Over-shift: counter saturates, tail replays the stream.
        rs = 30'($urandom);
        for (int e = 1; e <= 30; e++) begin
            if (e >= 25) chk("tail_replay", 32'(ccff_tail), 32'(rs[e-25]));
            step(rs[e-1], 1'b1, 1'b0);
        end
        chk("sat_cnt",  32'(cfg_bit_cnt), 24);
        chk("sat_full", 32'(cfg_full), 1);
        step(1'b1, 1'b1, 1'b1);
        chk("commit_shift_cnt", 32'(cfg_bit_cnt), 1);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0);
        chk("mid_cnt", 32'(cfg_bit_cnt), 13);
        #2 prog_reset = 1'b1;
        #1;
        chk("arst_cnt",    32'(cfg_bit_cnt), 0);
        chk("arst_active", 32'(cfg_active), 0);
        chk("arst_err",    32'(cfg_err), 0);
        chk("arst_tail",   32'(ccff_tail), 0);
        chk("arst_bottom", 32'(chany_bottom_out), 32'h140);
        chk("arst_left",   32'(chanx_left_out),   32'h140);
        repeat (2) @(posedge prog_clk);
        #1 prog_reset = 1'b0;
        repeat (2) @(posedge prog_clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sb_param_dbuf.md
Name: sb_param_dbuf

Overview:
- Parametrised corner switch block (bottom + left sides) generalising the fixed 9-track, 2:1-mux switch block.
- Channel width, pass-through count and mux count are parameters.
- Configuration chain is resettable and double-buffered: a shift stage plus an active shadow, updated only on an explicit commit. Bits are counted, and muxed tracks are held low until the first valid commit.
- Sits in the routing fabric between CLB/IO tiles, chained on ccff_head/ccff_tail like the existing switch blocks.

Parameters:
- CHAN_W, 9, tracks per channel side (>=3).
- N_PASS, 3, hard-wired pass-through tracks per side (1..CHAN_W-1).
- M, CHAN_W-N_PASS, derived: muxed tracks per side.
- CFG_BITS, 4*M, derived: 2 muxes-worth of bits (sel, en) per muxed track per side.
- CNT_W, $clog2(CFG_BITS+1), derived: bit-counter width.

Ports:
- prog_clk  in  1  sole clock, for configuration and status.
- prog_reset  in  1  asynchronous, active-high reset.
- ccff_head  in  1  serial configuration data in.
- ccff_shift_en  in  1  shift strobe; one bit per cycle when high.
- cfg_commit  in  1  copy the shift stage into the active configuration.
- chany_bottom_in  in  CHAN_W  bottom channel tracks in.
- chanx_left_in  in  CHAN_W  left channel tracks in.
- bottom_pin_in  in  M  grid output pins feeding bottom muxes.
- left_pin_in  in  M  grid output pins feeding left muxes.
- chany_bottom_out  out  CHAN_W  bottom channel tracks out.
- chanx_left_out  out  CHAN_W  left channel tracks out.
- ccff_tail  out  1  serial configuration data out: shift[CFG_BITS-1], registered.
- cfg_bit_cnt  out  CNT_W  bits shifted since reset/commit, saturating at CFG_BITS.
- cfg_full  out  1  cfg_bit_cnt == CFG_BITS.
- cfg_active  out  1  a valid commit has occurred since reset.
- cfg_err  out  1  sticky: commit attempted while !cfg_full.

Behaviour:
- Reset (async, prog_reset=1):
  - shift, active, cfg_bit_cnt, cfg_active and cfg_err all go to 0.
  - ccff_tail=0.
  - Muxed outputs go to 0. Pass-throughs stay live.
- Shift: on a prog_clk edge with ccff_shift_en=1, shift[0]<=ccff_head and shift[i]<=shift[i-1].
  - The first bit delivered ends at index CFG_BITS-1, so the bitstream is sent MSB-first.
  - cfg_bit_cnt increments and saturates at CFG_BITS.
  - Over-shifting is legal (the chain feeds downstream blocks) and raises no error.
- Commit: on an edge with cfg_commit=1 and cfg_full=1:
  - active<=shift, using pre-edge contents.
  - cfg_active<=1.
  - cfg_bit_cnt<=0, or 1 if ccff_shift_en is also high that edge. The shift still occurs.
- Commit with cfg_full=0: active is unchanged, cfg_err<=1 (sticky until reset), counter unchanged.
- Active layout:
  - Mux j uses active[2j]=sel and active[2j+1]=en.
  - j=0..M-1 are the bottom muxes for track j. j=M..2M-1 are the left muxes for track j-M.
- Bottom mux i drives chany_bottom_out[i]:
  - in0=bottom_pin_in[i], in1=chanx_left_in[(i+1) mod CHAN_W].
- Left mux i drives chanx_left_out[i]:
  - in0=chany_bottom_in[(i+CHAN_W-1) mod CHAN_W], in1=left_pin_in[i].
- Mux output = (cfg_active && en) ? (sel ? in1 : in0) : 0. Purely combinational from the active registers; zero latency.
- Pass-throughs, k=0..N_PASS-1, always combinational:
  - chanx_left_out[M+k] = chany_bottom_in[M-1+k].
  - chany_bottom_out[M+k] = chanx_left_in[(M+1+k) mod CHAN_W].
- Shifting never disturbs the routing outputs; only commit changes them.
- Reset mid-shift or mid-commit: the asynchronous clear wins; the partial stream is discarded.

Decomposition:
- Package sb_param_pkg:
  - cfg_bits(M) and cnt_w() constant functions.
  - Index functions bot_in1_idx(i,W), left_in0_idx(i,W), pass_src_idx(k,M,W).
  - Constants SEL_OFS=0, EN_OFS=1.
- Sub-module sb_cfg_dbuf_chain:
  - Parametrised on CFG_BITS; holds shift, active, counter, flags and ccff_tail.
  - The top level holds only the mux/pass-through wiring.

Test Plan (CHAN_W=9, N_PASS=3, M=6, CFG_BITS=24):
- Reset, then drive chany_bottom_in=9'h1A5 and chanx_left_in=9'h0F3 -> all muxed outputs 0, pass-throughs match the mapping, cfg_active=0, cfg_bit_cnt=0.
- Shift 24 bits with only bit1 (bottom mux 0 en)=1, sel=0, then commit -> chany_bottom_out[0] follows bottom_pin_in[0]; cfg_full=1 before commit, cfg_bit_cnt=0 and cfg_active=1 after.
- Commit after only 10 shifts -> active unchanged, cfg_err=1, cfg_bit_cnt=10.
- Active config set, shift a new 24-bit stream without commit -> outputs unchanged throughout; after commit the new selection applies on the next cycle.
- Shift 30 bits -> cfg_bit_cnt saturates at 24, and ccff_tail reproduces the 1st..6th input bits on the 25th..30th shift edges. Commit with ccff_shift_en high -> cfg_bit_cnt=1.
- Assert prog_reset asynchronously mid-stream after 12 shifts -> counter, flags and muxed outputs clear immediately, without waiting for a prog_clk edge.
